// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32 control FSM.
// States, opcodes, immediate-format codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_OP     = 3'd0,
    CLS_OP_IMM = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JALR   = 3'd5,
    CLS_NONE   = 3'd7
  } opclass_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_I_S   = 3'b000;
  localparam logic [2:0] IMM_SHAMT = 3'b001;
  localparam logic [2:0] IMM_I_U   = 3'b010;
  localparam logic [2:0] IMM_S     = 3'b011;
  localparam logic [2:0] IMM_B     = 3'b100;
  localparam logic [2:0] IMM_ZERO  = 3'b111;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/ctrl_imm_decode.sv
// Combinational opcode classifier: maps opcode/funct3 to the immediate
// format, an opcode class and a supported flag.
module ctrl_imm_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output logic [2:0] o_imm_sel,
  output opclass_t   o_opcode_class,
  output logic       o_supported
);

  always_comb begin
    o_imm_sel      = IMM_ZERO;
    o_opcode_class = CLS_NONE;
    o_supported    = 1'b1;
    case (i_opcode)
      OPC_OP: begin
        o_opcode_class = CLS_OP;
      end
      OPC_OP_IMM: begin
        o_opcode_class = CLS_OP_IMM;
        // Shifts take a shamt field; SLTIU compares unsigned.
        case (i_funct3)
          3'b001, 3'b101: o_imm_sel = IMM_SHAMT;
          3'b011:         o_imm_sel = IMM_I_U;
          default:        o_imm_sel = IMM_I_S;
        endcase
      end
      OPC_LOAD: begin
        o_opcode_class = CLS_LOAD;
        o_imm_sel      = IMM_I_S;
      end
      OPC_STORE: begin
        o_opcode_class = CLS_STORE;
        o_imm_sel      = IMM_S;
      end
      OPC_BRANCH: begin
        o_opcode_class = CLS_BRANCH;
        o_imm_sel      = IMM_B;
      end
      OPC_JALR: begin
        o_opcode_class = CLS_JALR;
        o_imm_sel      = IMM_I_S;
      end
      default: begin
        o_supported = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32 main controller: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer.
// Define CTRL_WATCHDOG_EN to trap after MEM_WAIT_MAX consecutive memory-wait cycles.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic [2:0]  imm_sel,
  output logic        alu_src_imm,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state_dbg
);

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] w_imm_sel;
  opclass_t   w_cls;
  logic       w_supported;
  logic       w_wd_trip;
  logic       w_unused_ins;

  // Only opcode and funct3 steer control; the rest of IR feeds the datapath.
  assign w_unused_ins = ^{ins[31:15], ins[11:7]};

  ctrl_imm_decode u_imm_decode (
    .i_opcode       (ins[6:0]),
    .i_funct3       (ins[14:12]),
    .o_imm_sel      (w_imm_sel),
    .o_opcode_class (w_cls),
    .o_supported    (w_supported)
  );

`ifdef CTRL_WATCHDOG_EN
  logic [31:0] r_wait_cnt;
  logic        w_waiting;

  assign w_waiting = ((r_state == FETCH) && !imem_ready) ||
                     ((r_state == MEM) && !dmem_ready);
  assign w_wd_trip = (MEM_WAIT_MAX != 0) && w_waiting &&
                     ((r_wait_cnt + 32'd1) >= 32'(MEM_WAIT_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (w_waiting) begin
      r_wait_cnt <= r_wait_cnt + 32'd1;
    end else begin
      r_wait_cnt <= '0;
    end
  end
`else
  logic [31:0] w_unused_wait_max;
  assign w_unused_wait_max = 32'(MEM_WAIT_MAX);
  assign w_wd_trip         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    imm_sel      = IMM_I_S;
    alu_src_imm  = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    illegal      = 1'b0;
    case (r_state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we        = 1'b1;
          w_state_next = DECODE;
        end else if (w_wd_trip) begin
          w_state_next = TRAP;
        end
      end
      DECODE: begin
        imm_sel      = w_imm_sel;
        w_state_next = w_supported ? EXEC : TRAP;
      end
      EXEC: begin
        imm_sel     = w_imm_sel;
        alu_src_imm = (w_cls != CLS_OP) && (w_cls != CLS_BRANCH);
        case (w_cls)
          CLS_BRANCH: begin
            pc_we        = 1'b1;
            pc_src       = branch_taken ? PC_BRANCH : PC_PLUS4;
            w_state_next = FETCH;
          end
          CLS_LOAD, CLS_STORE: w_state_next = MEM;
          default:             w_state_next = WB;
        endcase
      end
      MEM: begin
        imm_sel  = w_imm_sel;
        dmem_req = 1'b1;
        dmem_we  = (w_cls == CLS_STORE);
        if (dmem_ready) begin
          if (w_cls == CLS_STORE) begin
            pc_we        = 1'b1;
            w_state_next = FETCH;
          end else begin
            w_state_next = WB;
          end
        end else if (w_wd_trip) begin
          w_state_next = TRAP;
        end
      end
      WB: begin
        imm_sel      = w_imm_sel;
        rf_we        = 1'b1;
        pc_we        = 1'b1;
        wb_sel       = (w_cls == CLS_LOAD) ? WB_MEM :
                       (w_cls == CLS_JALR) ? WB_PC4 : WB_ALU;
        pc_src       = (w_cls == CLS_JALR) ? PC_ALU : PC_PLUS4;
        w_state_next = FETCH;
      end
      TRAP: begin
        imm_sel = IMM_ZERO;
        illegal = 1'b1;
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
    // Architectural strobes and a fresh fetch never fire while reset is held.
    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      rf_we    = 1'b0;
    end
  end

  assign state_dbg = r_state;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle main controller for the RV32 core.
- Sequences fetch, decode, execute, memory and writeback, one instruction at a time.
- Drives the immediate generator's 3-bit imm_sel, the PC, instruction-register, register-file and data-memory strobes, and handshakes with instruction and data memory.
- Sits between the instruction register (IR, external, holds `ins`) and the datapath muxes.

Parameters:
- MEM_WAIT_MAX, 0, max memory-wait cycles before the watchdog trap; 0 = unlimited. Used only with CTRL_WATCHDOG_EN.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- ins  in  32  current IR contents; stable from DECODE until the next ir_we
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- ir_we  out  1  load IR (single-cycle pulse)
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_ready  in  1  data access complete this cycle
- branch_taken  in  1  ALU comparison result for the current branch
- imm_sel  out  3  immediate format select to the immediate generator
- alu_src_imm  out  1  ALU operand B: 1 = immediate, 0 = rs2
- pc_we  out  1  PC update (single-cycle pulse)
- pc_src  out  2  0 = pc+4, 1 = pc+imm (branch), 2 = ALU result (jalr)
- rf_we  out  1  register write (single-cycle pulse)
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = pc+4
- illegal  out  1  sticky unsupported-opcode / watchdog flag
- state_dbg  out  3  current state encoding

Behaviour:
- Decisions:
  - One clock.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset:
  - state = FETCH, illegal = 0.
  - All strobes (imem_req excepted), imm_sel, pc_src and wb_sel = 0.
  - imem_req rises in the first cycle after reset deasserts.
- Outputs are combinational from the registered state plus ins[6:0] and ins[14:12]; no output is registered.
- States:
  - FETCH: imem_req = 1. Stay while !imem_ready. On imem_ready: ir_we = 1, go to DECODE.
  - DECODE: one cycle, imm_sel valid.
    - Supported opcodes: 0110011 OP, 0010011 OP-IMM, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1100111 JALR.
    - Supported opcode: go to EXEC. Any other opcode: go to TRAP.
  - EXEC: one cycle; alu_src_imm = 1 for all supported opcodes except OP and BRANCH.
    - BRANCH: pc_we = 1, pc_src = branch_taken ? 1 : 0, go to FETCH.
    - LOAD/STORE: go to MEM.
    - OP/OP-IMM/JALR: go to WB.
  - MEM: dmem_req = 1, dmem_we = (opcode == STORE). Hold until dmem_ready.
    - On dmem_ready, store: pc_we = 1, pc_src = 0, go to FETCH.
    - On dmem_ready, load: go to WB.
  - WB: rf_we = 1, pc_we = 1, go to FETCH.
    - wb_sel = 1 for LOAD, 2 for JALR, else 0.
    - pc_src = 2 for JALR, else 0.
  - TRAP: illegal = 1, all strobes 0. Left only by rst.
- imm_sel, held from DECODE through WB:
  - OP-IMM with funct3 001/101: 001.
  - OP-IMM with funct3 011: 010.
  - Other OP-IMM, LOAD, JALR: 000.
  - STORE: 011.
  - BRANCH: 100.
  - OP and TRAP: 111 (zero immediate).
- Latency, cycles with zero memory wait:
  - BRANCH 3.
  - OP, OP-IMM, JALR, STORE 4.
  - LOAD 5.
  - Each wait cycle on a ready input adds one.
- Boundaries:
  - imem_ready / dmem_ready outside FETCH / MEM are ignored.
  - ready high on the same cycle as the request completes in that cycle.
  - rst mid-MEM or mid-FETCH drops the request the next cycle; memory must tolerate abandoned requests.
  - rst has priority over every transition.
  - ir_we, pc_we and rf_we are never asserted in the same cycle as rst.

Optional Feature:
- Macro: CTRL_WATCHDOG_EN.
- When defined:
  - An internal wait counter counts consecutive cycles in FETCH or MEM without ready, and clears on leaving the state.
  - If MEM_WAIT_MAX != 0 and the counter reaches MEM_WAIT_MAX, go to TRAP and set illegal.
- When undefined: no counter; waits are unbounded and MEM_WAIT_MAX is ignored.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC, MEM, WB, TRAP)
  - opcode localparams
  - imm_sel codes: IMM_I_S = 000, IMM_SHAMT = 001, IMM_I_U = 010, IMM_S = 011, IMM_B = 100, IMM_ZERO = 111
  - pc_src and wb_sel codes
- Sub-module ctrl_imm_decode: combinational ins → {imm_sel, opcode_class, supported}.

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093), zero wait:
  - Expect ir_we at cycle 1, then imm_sel = 000 and alu_src_imm = 1.
  - Expect rf_we and pc_we at cycle 4 with wb_sel = 0, pc_src = 0.
- SRAI (0x4020D093) then SLTIU (0x0010B093):
  - Expect imm_sel 001, then 010.
  - Expect 4 cycles each.
- LW with dmem_ready delayed 3 cycles:
  - Expect dmem_req held for 4 cycles, dmem_we = 0.
  - Expect rf_we with wb_sel = 1; total 8 cycles.
- BEQ (0x00208463):
  - branch_taken = 1: pc_we with pc_src = 1 at cycle 3.
  - branch_taken = 0: pc_src = 0.
- Opcode 0110111 (LUI):
  - Expect TRAP after DECODE, illegal = 1 sticky, no pc_we/rf_we.
  - Expect rst to return the block to FETCH with illegal = 0.
- SW with rst asserted mid-MEM:
  - Expect dmem_req = 0 the next cycle, state_dbg = FETCH, and no pc_we.
  - With CTRL_WATCHDOG_EN and MEM_WAIT_MAX = 4, a stalled SW traps after 4 wait cycles.
